fetch_ctrl: RTL and testbench

Instruction-fetch controller that consumes the PC register's output and drives its enable, so the PC advances only when an instruction has actually been fetched. It issues one request at a time to instruction memory using a valid/ready request and a fixed-accept response. Fetched words go to IF/ID through a one-entry output register plus a one-entry skid buffer, and the block honours decode stall and branch-redirect flush.

---
 rtl/fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_fetch_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller.
// Issues one memory request at a time for the address held in the PC register,
// pulses the PC enable when a fetched word is taken, and hands words to IF/ID
// through an output register backed by a one-entry skid buffer. A redirect
// (IFC_FLUSH) empties both entries and discards any response still in flight.
module fetch_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             IFC_CLK,
    input  logic             IFC_RST,
    input  logic [WIDTH-1:0] IFC_PC,
    output logic             IFC_PC_EN,
    input  logic             IFC_FLUSH,
    input  logic             IFC_STALL,
    output logic             IFC_REQ_VALID,
    output logic [WIDTH-1:0] IFC_REQ_ADDR,
    input  logic             IFC_REQ_READY,
    input  logic             IFC_RSP_VALID,
    input  logic [WIDTH-1:0] IFC_RSP_DATA,
    output logic [WIDTH-1:0] IFC_INSTR,
    output logic             IFC_INSTR_VALID
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] addr_reg;
    logic             req_valid_reg;
    logic             drop_reg;
    logic [WIDTH-1:0] instr_reg;
    logic             instr_valid_reg;
    logic [WIDTH-1:0] skid_reg;
    logic             skid_valid_reg;

    logic rsp_accept;
    logic consume;

    // A response is taken only in WAIT, when it was not orphaned by an earlier
    // redirect and is not coincident with a redirect.
    assign rsp_accept = (state_reg == ST_WAIT) && IFC_RSP_VALID && !drop_reg && !IFC_FLUSH;
    assign consume    = instr_valid_reg && !IFC_STALL;

    // The PC moves either to the next sequential word (word taken) or to the
    // branch target (redirect); it must stay put while reset is held.
    assign IFC_PC_EN       = !IFC_RST && (rsp_accept || IFC_FLUSH);
    assign IFC_REQ_VALID   = req_valid_reg;
    assign IFC_REQ_ADDR    = addr_reg;
    assign IFC_INSTR       = instr_reg;
    assign IFC_INSTR_VALID = instr_valid_reg;

    // Request state machine: latch PC, hold the request until accepted, await the word.
    always_ff @(posedge IFC_CLK or posedge IFC_RST) begin
        if (IFC_RST) begin
            state_reg     <= ST_LOAD;
            addr_reg      <= '0;
            req_valid_reg <= 1'b0;
            drop_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    // A redirect this cycle means IFC_PC is not yet the target;
                    // a full skid buffer means there is nowhere to put another word.
                    if (!IFC_FLUSH && !skid_valid_reg) begin
                        addr_reg      <= IFC_PC;
                        req_valid_reg <= 1'b1;
                        state_reg     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (IFC_FLUSH) begin
                        drop_reg <= 1'b1;
                    end
                    if (IFC_REQ_READY) begin
                        req_valid_reg <= 1'b0;
                        state_reg     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (IFC_RSP_VALID) begin
                        // The response closes the transaction whether it is kept,
                        // dropped by the flag, or dropped by a coincident redirect.
                        drop_reg  <= 1'b0;
                        state_reg <= ST_LOAD;
                    end else if (IFC_FLUSH) begin
                        drop_reg <= 1'b1;
                    end
                end
                default: begin
                    req_valid_reg <= 1'b0;
                    state_reg     <= ST_LOAD;
                end
            endcase
        end
    end

    // Output register and skid buffer: refill on consumption, park a word when blocked.
    always_ff @(posedge IFC_CLK or posedge IFC_RST) begin
        if (IFC_RST) begin
            instr_reg       <= '0;
            instr_valid_reg <= 1'b0;
            skid_reg        <= '0;
            skid_valid_reg  <= 1'b0;
        end else if (IFC_FLUSH) begin
            instr_valid_reg <= 1'b0;
            skid_valid_reg  <= 1'b0;
        end else if (consume) begin
            if (skid_valid_reg) begin
                instr_reg      <= skid_reg;
                skid_valid_reg <= 1'b0;
            end else if (rsp_accept) begin
                instr_reg <= IFC_RSP_DATA;
            end else begin
                instr_valid_reg <= 1'b0;
            end
        end else if (!instr_valid_reg) begin
            if (rsp_accept) begin
                instr_reg       <= IFC_RSP_DATA;
                instr_valid_reg <= 1'b1;
            end
        end else if (rsp_accept) begin
            // Output register is occupied and stalled: the word waits in the skid.
            skid_reg       <= IFC_RSP_DATA;
            skid_valid_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: a PC register, a randomized single-request memory
// and an IF/ID consumer surround the DUT. The reference is the program-order
// instruction stream: IF/ID must see mem(pc), mem(pc+4), ... restarting at the
// redirect target after every flush, with the PC enable pulsing exactly for
// redirects and for responses that were not orphaned by a redirect.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        pc_en;
    logic        flush;
    logic        stall;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [31:0] instr;
    logic        instr_valid;

    fetch_ctrl #(.WIDTH(32)) dut (
        .IFC_CLK        (clk),
        .IFC_RST        (rst),
        .IFC_PC         (pc),
        .IFC_PC_EN      (pc_en),
        .IFC_FLUSH      (flush),
        .IFC_STALL      (stall),
        .IFC_REQ_VALID  (req_valid),
        .IFC_REQ_ADDR   (req_addr),
        .IFC_REQ_READY  (ready),
        .IFC_RSP_VALID  (rsp_valid),
        .IFC_RSP_DATA   (rsp_data),
        .IFC_INSTR      (instr),
        .IFC_INSTR_VALID(instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // stimulus knobs
    int rdy_pct, stall_pct, flush_pct, spur_pct, lat_min, lat_max;

    // environment / reference state
    int          cyc;
    bit          pend;
    logic [31:0] pend_addr;
    int          rsp_cyc;
    bit          stale;
    logic [31:0] exp_pc;
    logic [31:0] target;
    int          n_consumed;
    bit          nx_pc_en, nx_flush, nx_accept, nx_rsp_done, prev_hold;
    logic [31:0] nx_target, nx_acc_addr, prev_addr;
    int          nx_lat;

    // instruction memory contents as a function of address
    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h2008_0005;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        cyc = 0; pend = 0; pend_addr = '0; rsp_cyc = 0; stale = 0; exp_pc = '0;
        nx_pc_en = 0; nx_flush = 0; nx_accept = 0; nx_rsp_done = 0; prev_hold = 0;
        nx_target = '0; nx_acc_addr = '0; prev_addr = '0; nx_lat = 1;
        pc = '0;
    endtask

    // One clock cycle: commit last cycle's effects, drive inputs, sample and check.
    task automatic run_cycle();
        bit real_rsp;
        bit exp_en;
        @(posedge clk);
        #1;
        cyc++;
        if (nx_pc_en) pc = nx_flush ? nx_target : pc + 32'd4;
        if (nx_rsp_done) pend = 0;
        if (nx_accept) begin
            pend      = 1;
            pend_addr = nx_acc_addr;
            rsp_cyc   = cyc - 1 + nx_lat;
        end

        ready  = (int'($urandom_range(0, 99)) < rdy_pct);
        flush  = (int'($urandom_range(0, 99)) < flush_pct);
        target = 32'($urandom_range(0, 1023)) << 2;
        stall  = flush ? 1'b1 : (int'($urandom_range(0, 99)) < stall_pct);
        real_rsp = pend && (cyc == rsp_cyc);
        if (real_rsp) begin
            rsp_valid = 1'b1;
            rsp_data  = memw(pend_addr);
        end else if (!pend && (int'($urandom_range(0, 99)) < spur_pct)) begin
            rsp_valid = 1'b1;
            rsp_data  = $urandom;
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = $urandom;
        end
        #1;

        if (prev_hold) begin
            check("req_held_valid", 32'(req_valid), 32'd1);
            check("req_held_addr", req_addr, prev_addr);
        end
        if (req_valid && ready) check("one_outstanding", 32'(pend), 32'd0);
        exp_en = flush || (real_rsp && !stale);
        check("pc_en", 32'(pc_en), 32'(exp_en));
        if (instr_valid && !stall) begin
            check("instr", instr, memw(exp_pc));
            $display("cycle %0d: fetched pc=0x%08h instr=0x%08h", cyc, exp_pc, instr);
            exp_pc = exp_pc + 32'd4;
            n_consumed++;
        end
        if (flush) exp_pc = target;

        if (real_rsp) stale = 0;
        else if (flush && (req_valid || pend)) stale = 1;

        nx_pc_en    = pc_en;
        nx_flush    = flush;
        nx_target   = target;
        nx_accept   = req_valid && ready;
        nx_acc_addr = req_addr;
        nx_lat      = int'($urandom_range(lat_min, lat_max));
        nx_rsp_done = real_rsp;
        prev_hold   = req_valid && !ready;
        prev_addr   = req_addr;
    endtask

    task automatic set_knobs(input int r, input int s, input int f, input int sp,
                             input int lmin, input int lmax);
        rdy_pct = r; stall_pct = s; flush_pct = f; spur_pct = sp;
        lat_min = lmin; lat_max = lmax;
    endtask

    // Zero-wait memory from a fresh reset release with PC=0.
    task automatic latency_test(input string pfx);
        set_knobs(100, 0, 0, 0, 1, 1);
        run_cycle();
        check({pfx, "_c1_req_valid"}, 32'(req_valid), 32'd1);
        check({pfx, "_c1_req_addr"}, req_addr, 32'h0);
        check({pfx, "_c1_pc_en"}, 32'(pc_en), 32'd0);
        run_cycle();
        check({pfx, "_c2_pc_en"}, 32'(pc_en), 32'd1);
        check({pfx, "_c2_instr_valid"}, 32'(instr_valid), 32'd0);
        run_cycle();
        check({pfx, "_c3_instr_valid"}, 32'(instr_valid), 32'd1);
        check({pfx, "_c3_instr"}, instr, memw(32'h0));
        check({pfx, "_c3_pc_en"}, 32'(pc_en), 32'd0);
        run_cycle();
        check({pfx, "_c4_req_addr"}, req_addr, 32'h4);
    endtask

    initial begin
        bit reached;
        n_consumed = 0;
        model_reset();
        set_knobs(0, 0, 0, 0, 1, 1);
        rst = 1'b1; flush = 1'b1; stall = 1'b0; ready = 1'b1;
        rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF; target = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_req_addr", req_addr, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc_en", 32'(pc_en), 32'd0);

        flush = 1'b0; rsp_valid = 1'b0; ready = 1'b0;
        rst = 1'b0;
        latency_test("lat");

        set_knobs(60, 30, 3, 10, 1, 3);
        repeat (1500) run_cycle();
        set_knobs(50, 80, 3, 10, 1, 4);
        repeat (1500) run_cycle();
        set_knobs(100, 0, 2, 0, 1, 1);
        repeat (500) run_cycle();

        // Reach WAIT with a word held in IF/ID, then reset asynchronously.
        set_knobs(100, 100, 0, 0, 4, 4);
        reached = 0;
        for (int i = 0; i < 60 && !reached; i++) begin
            run_cycle();
            if (pend && instr_valid && !rsp_valid) reached = 1;
        end
        check("rst_mid_wait_reached", 32'(reached), 32'd1);
        #2;
        rst = 1'b1; flush = 1'b1;
        #1;
        check("arst_req_valid", 32'(req_valid), 32'd0);
        check("arst_instr_valid", 32'(instr_valid), 32'd0);
        check("arst_pc_en", 32'(pc_en), 32'd0);
        $display("cycle %0d: asynchronous reset mid-WAIT", cyc);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        flush = 1'b0; rsp_valid = 1'b0; ready = 1'b0; stall = 1'b0;
        rst = 1'b0;
        latency_test("post_rst");

        check("progress", 32'(n_consumed > 100), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
